// File: rtl/bus_arbiter.sv
// Two-master data-memory bus arbiter: round-robin on ties, bounded hold with
// pre-emption only between accesses, one turnaround cycle between owners.
module bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,

   input  logic       m0_bus_req,
   output logic       m0_bus_grant,
   input  logic       m0_wr,
   input  logic       m0_rd,
   input  logic [7:0] m0_addr,
   input  logic [7:0] m0_dout,

   input  logic       m1_bus_req,
   output logic       m1_bus_grant,
   input  logic       m1_wr,
   input  logic       m1_rd,
   input  logic [7:0] m1_addr,
   input  logic [7:0] m1_dout,

   output logic       bus_wr,
   output logic       bus_rd,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_dout,
   output logic       bus_err
);

   localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;
   localparam logic [1:0] TURN = 2'd3;

   // The counter saturates at MAX_HOLD, so "at least MAX_HOLD cycles held,
   // counting the current one" is exactly one of these two values.
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_expired;
   logic             last_owner;
   logic             armed;
   logic             grant_entry;
   logic             proto_err;

   assign hold_expired = (MAX_HOLD != 0) &&
                         ((hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_SAT));

   assign grant_entry = (state == IDLE) && (state_next != IDLE);

   // Arbitration only starts once one edge has passed after reset release.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         IDLE: begin
            if (armed) begin
               if (m0_bus_req && m1_bus_req) begin
                  state_next = last_owner ? GNT0 : GNT1;
               end else if (m0_bus_req) begin
                  state_next = GNT0;
               end else if (m1_bus_req) begin
                  state_next = GNT1;
               end
            end
         end
         GNT0: begin
            if (!m0_bus_req ||
                (hold_expired && m1_bus_req && !m0_wr && !m0_rd)) begin
               state_next = TURN;
            end
         end
         GNT1: begin
            if (!m1_bus_req ||
                (hold_expired && m0_bus_req && !m1_wr && !m1_rd)) begin
               state_next = TURN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         armed        <= 1'b0;
         m0_bus_grant <= 1'b0;
         m1_bus_grant <= 1'b0;
      end else begin
         state        <= state_next;
         armed        <= 1'b1;
         m0_bus_grant <= (state_next == GNT0);
         m1_bus_grant <= (state_next == GNT1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt <= '0;
      end else if (grant_entry) begin
         hold_cnt <= '0;
      end else if (((state == GNT0) || (state == GNT1)) && (hold_cnt != HOLD_SAT)) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   // Reset value 1 lets master 0 win the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner <= 1'b1;
      end else if (grant_entry) begin
         last_owner <= (state_next == GNT1);
      end
   end

   assign proto_err = (!m0_bus_grant && (m0_wr || m0_rd)) ||
                      (!m1_bus_grant && (m1_wr || m1_rd)) ||
                      (m0_bus_grant && m0_wr && m0_rd)    ||
                      (m1_bus_grant && m1_wr && m1_rd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_err <= 1'b0;
      end else begin
         bus_err <= proto_err;
      end
   end

   // Ungranted masters are masked off; with no grant every bus output is 0.
   assign bus_wr   = (m0_bus_grant & m0_wr) | (m1_bus_grant & m1_wr);
   assign bus_rd   = (m0_bus_grant & m0_rd) | (m1_bus_grant & m1_rd);
   assign bus_addr = ({8{m0_bus_grant}} & m0_addr) | ({8{m1_bus_grant}} & m1_addr);
   assign bus_dout = ({8{m0_bus_grant}} & m0_dout) | ({8{m1_bus_grant}} & m1_dout);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: one instance with MAX_HOLD=16 and one with pre-emption
// disabled, both compared every cycle against an ownership-level reference model.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       m0_bus_req, m0_wr, m0_rd;
   logic [7:0] m0_addr, m0_dout;
   logic       m1_bus_req, m1_wr, m1_rd;
   logic [7:0] m1_addr, m1_dout;

   logic [1:0]      g0, g1, bwr, brd, berr;
   logic [1:0][7:0] baddr, bdout;

   int checks   = 0;
   int failures = 0;

   // Reference model, per instance: owner (-1 none), cycles held, turnaround pending.
   int unsigned mh[2] = '{16, 0};
   int          own[2];
   int          held[2];
   int          gap[2];
   int          last[2];
   bit          armed[2];
   bit          err_e[2];

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_HOLD(16)) u_dut (
      .clk(clk), .rst(rst),
      .m0_bus_req(m0_bus_req), .m0_bus_grant(g0[0]), .m0_wr(m0_wr), .m0_rd(m0_rd),
      .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m1_bus_req(m1_bus_req), .m1_bus_grant(g1[0]), .m1_wr(m1_wr), .m1_rd(m1_rd),
      .m1_addr(m1_addr), .m1_dout(m1_dout),
      .bus_wr(bwr[0]), .bus_rd(brd[0]), .bus_addr(baddr[0]), .bus_dout(bdout[0]),
      .bus_err(berr[0])
   );

   bus_arbiter #(.MAX_HOLD(0)) u_dut_nohold (
      .clk(clk), .rst(rst),
      .m0_bus_req(m0_bus_req), .m0_bus_grant(g0[1]), .m0_wr(m0_wr), .m0_rd(m0_rd),
      .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m1_bus_req(m1_bus_req), .m1_bus_grant(g1[1]), .m1_wr(m1_wr), .m1_rd(m1_rd),
      .m1_addr(m1_addr), .m1_dout(m1_dout),
      .bus_wr(bwr[1]), .bus_rd(brd[1]), .bus_addr(baddr[1]), .bus_dout(bdout[1]),
      .bus_err(berr[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit req_of(int m);
      return (m == 0) ? m0_bus_req : m1_bus_req;
   endfunction

   function automatic bit busy_of(int m);
      return (m == 0) ? (m0_wr || m0_rd) : (m1_wr || m1_rd);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         own[i] = -1; held[i] = 0; gap[i] = 0; last[i] = 1; armed[i] = 0; err_e[i] = 0;
      end
   endtask

   // Advance the model by one rising edge using the inputs of the closing cycle.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit v;
         v = (own[i] != 0 && busy_of(0)) || (own[i] != 1 && busy_of(1)) ||
             (own[i] == 0 && m0_wr && m0_rd) || (own[i] == 1 && m1_wr && m1_rd);
         err_e[i] = v;
         if (!armed[i]) begin
            armed[i] = 1;
         end else if (own[i] >= 0) begin
            int x;
            x = own[i];
            held[i]++;
            if (!req_of(x) ||
                (mh[i] > 0 && held[i] >= int'(mh[i]) && req_of(1 - x) && !busy_of(x))) begin
               own[i] = -1;
               gap[i] = 1;
            end
         end else if (gap[i] > 0) begin
            gap[i] = 0;
         end else if (req_of(0) || req_of(1)) begin
            if (req_of(0) && req_of(1)) own[i] = 1 - last[i];
            else                        own[i] = req_of(0) ? 0 : 1;
            last[i] = own[i];
            held[i] = 0;
         end
      end
   endtask

   function automatic logic [20:0] exp_outs(int i);
      logic       w, r;
      logic [7:0] a, d;
      w = 0; r = 0; a = 0; d = 0;
      if (own[i] == 0) begin
         w = m0_wr; r = m0_rd; a = m0_addr; d = m0_dout;
      end else if (own[i] == 1) begin
         w = m1_wr; r = m1_rd; a = m1_addr; d = m1_dout;
      end
      return {own[i] == 0, own[i] == 1, w, r, err_e[i], a, d};
   endfunction

   function automatic logic [20:0] obs_outs(int i);
      return {g0[i], g1[i], bwr[i], brd[i], berr[i], baddr[i], bdout[i]};
   endfunction

   // Compare both instances mid-cycle, then cross one rising edge.
   task automatic tick();
      @(negedge clk);
      check("outs_hold16", {11'd0, obs_outs(0)}, {11'd0, exp_outs(0)});
      check("outs_nohold", {11'd0, obs_outs(1)}, {11'd0, exp_outs(1)});
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      m0_bus_req = 0; m0_wr = 0; m0_rd = 0; m0_addr = 0; m0_dout = 0;
      m1_bus_req = 0; m1_wr = 0; m1_rd = 0; m1_addr = 0; m1_dout = 0;
   endtask

   task automatic go_idle();
      clear_inputs();
      repeat (4) tick();
   endtask

   // m0 holds its request for len granted cycles with m1 requesting throughout.
   task automatic hold_test(input int len, input int rd_lo, input int rd_hi,
                            input int exp_len16);
      int  cnt16, cnt0, first_g1;
      bit  dropped16;
      go_idle();
      m0_bus_req = 1;
      for (int t = 0; t < 5 && own[0] != 0; t++) tick();
      check("hold_m0_granted", {g0[1], g0[0]}, 2'b11);
      m1_bus_req = 1;
      cnt16 = 0; cnt0 = 0; first_g1 = 0; dropped16 = 0;
      for (int c = 1; c <= len; c++) begin
         if (g0[0] && !dropped16) cnt16++;
         else                     dropped16 = 1;
         if (g0[1]) cnt0++;
         if (g1[0] && first_g1 == 0) first_g1 = c;
         m0_rd = (c >= rd_lo && c <= rd_hi);
         tick();
      end
      m0_bus_req = 0;
      m0_rd      = 0;
      check("hold16_len", cnt16, exp_len16);
      check("hold16_m1_gap", first_g1, exp_len16 + 3);
      check("nohold_len", cnt0, len);
      repeat (3) tick();
      check("nohold_m1_after_release", g1[1], 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      model_reset();
      rst = 0;
      m0_bus_req = 1;
      m1_bus_req = 1;
      #13;
      check("rst_outs_hold16", {11'd0, obs_outs(0)}, 32'd0);
      check("rst_outs_nohold", {11'd0, obs_outs(1)}, 32'd0);

      // Tie after reset: no grant at the first edge, m0 at the second.
      @(posedge clk);
      #2 rst = 1;
      tick();
      check("first_edge_no_grant", {g1, g0}, 4'b0000);
      tick();
      check("tie_grants_m0", {g1[0], g0[0]}, 2'b01);
      repeat (3) tick();
      m0_bus_req = 0;
      tick();
      check("release_drops_grant", {g1[0], g0[0]}, 2'b00);
      tick();
      check("turn_no_grant", {g1[0], g0[0]}, 2'b00);
      tick();
      check("m1_two_edges_after", {g1[0], g0[0]}, 2'b10);
      m1_bus_req = 0;

      hold_test(40, 0, -1, 16);
      hold_test(40, 15, 18, 19);
      hold_test(100, 0, -1, 16);

      // Ungranted m1 strobes must not reach the bus and must raise bus_err once.
      go_idle();
      m0_bus_req = 1;
      for (int t = 0; t < 5 && own[0] != 0; t++) tick();
      m0_addr = 8'hA5; m0_dout = 8'h5A; m0_wr = 1;
      m1_addr = 8'h3C; m1_dout = 8'hC3; m1_wr = 1;
      #1;
      check("bus_addr_m0", baddr[0], 8'hA5);
      check("bus_wr_m0", bwr[0], 1'b1);
      tick();
      m1_wr = 0; m0_wr = 0;
      #1;
      check("bus_wr_follows_m0", bwr[0], 1'b0);
      check("bus_err_pulse", berr[0], 1'b1);
      tick();
      check("bus_err_one_cycle", berr[0], 1'b0);

      // Asynchronous reset mid-write drops the grant without a clock edge.
      go_idle();
      m1_bus_req = 1;
      for (int t = 0; t < 5 && own[0] != 1; t++) tick();
      m1_wr = 1; m1_addr = 8'h77;
      #1;
      check("pre_rst_bus_wr", bwr[0], 1'b1);
      #2 rst = 0;
      #1;
      check("async_grant_drop", {g1, g0}, 4'b0000);
      check("async_bus_wr_drop", bwr, 2'b00);
      model_reset();
      clear_inputs();
      m0_bus_req = 1;
      m1_bus_req = 1;
      @(posedge clk);
      #2 rst = 1;
      tick();
      tick();
      check("tie_after_rst", {g1[0], g0[0]}, 2'b01);

      // Randomised traffic with long holds and occasional protocol violations.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(23) == 0) m0_bus_req = ~m0_bus_req;
         if ($urandom_range(23) == 0) m1_bus_req = ~m1_bus_req;
         m0_wr = 0; m0_rd = 0; m1_wr = 0; m1_rd = 0;
         if (own[0] == 0) begin
            case ($urandom_range(15))
               0, 1, 2: m0_wr = 1;
               3, 4, 5: m0_rd = 1;
               6:       begin m0_wr = 1; m0_rd = 1; end
               default: ;
            endcase
         end else if ($urandom_range(31) == 0) begin
            m0_rd = 1;
         end
         if (own[0] == 1) begin
            case ($urandom_range(15))
               0, 1, 2: m1_wr = 1;
               3, 4, 5: m1_rd = 1;
               6:       begin m1_wr = 1; m1_rd = 1; end
               default: ;
            endcase
         end else if ($urandom_range(31) == 0) begin
            m1_wr = 1;
         end
         m0_addr = 8'($urandom); m0_dout = 8'($urandom);
         m1_addr = 8'($urandom); m1_dout = 8'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
